exe_stage: RTL and testbench

//  Execute stage of the 5-stage MIPS pipeline, directly downstream of the decode stage.
//  - Consumes ds_to_es_bus; runs the existing alu for the 12 base ops.
//  - Owns the HI/LO registers; multiply is single-cycle, divide is iterative (33 cycles).
//  - Issues the data SRAM request and forwards results and exception status to the memory stage.

---
 rtl/exe_stage_pkg.sv | 85 ++++++++
 rtl/alu.sv | 39 +++
 rtl/exe_stage_div.sv | 95 +++++++++
 rtl/exe_stage.sv | 138 +++++++++++++
 tb/tb_exe_stage.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_stage_pkg.sv
// Shared types and constants for the execute stage: bus layouts, ALU/MD op indices, excodes.
// No logic; widths here set the port widths of exe_stage.
// Bus structs are packed so they can be cast to and from the flat pipeline buses.
package exe_stage_pkg;

    localparam int ALU_OP_WD = 12;
    localparam int ALU_ADD  = 0;
    localparam int ALU_SUB  = 1;
    localparam int ALU_SLT  = 2;
    localparam int ALU_SLTU = 3;
    localparam int ALU_AND  = 4;
    localparam int ALU_NOR  = 5;
    localparam int ALU_OR   = 6;
    localparam int ALU_XOR  = 7;
    localparam int ALU_SLL  = 8;
    localparam int ALU_SRL  = 9;
    localparam int ALU_SRA  = 10;
    localparam int ALU_LUI  = 11;

    localparam int MD_OP_MULT = 0;
    localparam int MD_OP_DIV  = 1;
    localparam int MD_OP_MFHI = 2;
    localparam int MD_OP_MFLO = 3;
    localparam int MD_OP_MTHI = 4;
    localparam int MD_OP_MTLO = 5;

    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    typedef struct packed {
        logic                 ex;
        logic [4:0]           excode;
        logic [5:0]           md_op;
        logic                 signed_op;
        logic [ALU_OP_WD-1:0] alu_op;
        logic                 src1_is_sa;
        logic                 src1_is_pc;
        logic                 src2_is_imm;
        logic                 src2_is_8;
        logic                 gr_we;
        logic                 mem_we;
        logic                 res_from_mem;
        logic [4:0]           dest;
        logic [15:0]          imm;
        logic [31:0]          rs_value;
        logic [31:0]          rt_value;
        logic [31:0]          pc;
    } ds_to_es_t;

    typedef struct packed {
        logic        ex;
        logic [4:0]  excode;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        vld;
        logic [4:0]  dest;
        logic [31:0] dat;
    } es_fwd_t;

    localparam int DS_TO_ES_BUS_WD = $bits(ds_to_es_t);
    localparam int ES_TO_MS_BUS_WD = $bits(es_to_ms_t);
    localparam int ES_FWD_BUS_WD   = $bits(es_fwd_t);

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

    function automatic logic [31:0] mag32(input logic [31:0] v, input logic is_signed);
        return (is_signed && v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/alu.sv
// Base integer ALU for the 12 one-hot ops (add/sub/slt/sltu/and/nor/or/xor/sll/srl/sra/lui).
// Purely combinational, zero latency.
// No flow control; the enclosing stage owns the handshake.
module alu
    import exe_stage_pkg::*;
(
    input  logic [ALU_OP_WD-1:0] alu_op,
    input  logic [31:0]          alu_src1,
    input  logic [31:0]          alu_src2,
    output logic [31:0]          alu_result
);

    logic [31:0] add_res;
    logic [31:0] sub_res;
    logic [31:0] sra_res;
    logic        slt_res;
    logic        sltu_res;

    assign add_res  = alu_src1 + alu_src2;
    assign sub_res  = alu_src1 - alu_src2;
    assign slt_res  = $signed(alu_src1) < $signed(alu_src2);
    assign sltu_res = alu_src1 < alu_src2;
    // Shifts move src2 (rt) by src1[4:0] (sa or rs).
    assign sra_res  = $signed(alu_src2) >>> alu_src1[4:0];

    assign alu_result = ({32{alu_op[ALU_ADD]}}  & add_res)
                      | ({32{alu_op[ALU_SUB]}}  & sub_res)
                      | ({32{alu_op[ALU_SLT]}}  & {31'b0, slt_res})
                      | ({32{alu_op[ALU_SLTU]}} & {31'b0, sltu_res})
                      | ({32{alu_op[ALU_AND]}}  & (alu_src1 & alu_src2))
                      | ({32{alu_op[ALU_NOR]}}  & ~(alu_src1 | alu_src2))
                      | ({32{alu_op[ALU_OR]}}   & (alu_src1 | alu_src2))
                      | ({32{alu_op[ALU_XOR]}}  & (alu_src1 ^ alu_src2))
                      | ({32{alu_op[ALU_SLL]}}  & (alu_src2 << alu_src1[4:0]))
                      | ({32{alu_op[ALU_SRL]}}  & (alu_src2 >> alu_src1[4:0]))
                      | ({32{alu_op[ALU_SRA]}}  & sra_res)
                      | ({32{alu_op[ALU_LUI]}}  & {alu_src2[15:0], 16'b0});

endmodule

// File: rtl/exe_stage_div.sv
// Iterative radix-2 restoring divider (signed via magnitudes) with IDLE/RUN/DONE control.
// Latency: start seen in IDLE, DIV_CYCLES iterations in RUN, then DONE holds q/r.
// Backpressure: DONE holds until abort; abort (flush or retire) returns to IDLE from any state.
module div_iter
    import exe_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        abort,
    input  logic        signed_op,
    input  logic [31:0] x,
    input  logic [31:0] y,
    output logic        busy,
    output logic        done,
    output logic [31:0] q,
    output logic [31:0] r
);

    localparam int CW = $clog2(DIV_CYCLES + 1);

    div_state_t    state;
    div_state_t    state_nxt;
    logic [CW-1:0] cnt;
    logic [31:0]   quo;
    logic [31:0]   rem;
    logic [31:0]   ymag;
    logic          neg_q;
    logic          neg_r;
    logic [32:0]   trial;
    logic [32:0]   diff;
    logic          last_iter;

    assign trial     = {rem, quo[31]};
    assign diff      = trial - {1'b0, ymag};
    assign last_iter = (cnt == CW'(DIV_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= DIV_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = DIV_IDLE;
        end else begin
            case (state)
                DIV_IDLE: if (start)     state_nxt = DIV_RUN;
                DIV_RUN:  if (last_iter) state_nxt = DIV_DONE;
                DIV_DONE: state_nxt = DIV_DONE;
                default:  state_nxt = DIV_IDLE;
            endcase
        end
    end

    always_comb begin
        busy = (state == DIV_RUN);
        done = (state == DIV_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt   <= '0;
            quo   <= '0;
            rem   <= '0;
            ymag  <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (state == DIV_IDLE && start && !abort) begin
            cnt   <= '0;
            quo   <= mag32(x, signed_op);
            rem   <= '0;
            ymag  <= mag32(y, signed_op);
            neg_q <= signed_op && (x[31] ^ y[31]);
            neg_r <= signed_op && x[31];
        end else if (state == DIV_RUN && !abort) begin
            cnt <= cnt + CW'(1);
            // A zero divisor always "fits", giving all-ones quotient and remainder = dividend.
            if (!diff[32]) begin
                rem <= diff[31:0];
                quo <= {quo[30:0], 1'b1};
            end else begin
                rem <= trial[31:0];
                quo <= {quo[30:0], 1'b0};
            end
        end
    end

    assign q = neg_q ? (~quo + 32'd1) : quo;
    assign r = neg_r ? (~rem + 32'd1) : rem;

endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: ALU, HI/LO with 1-cycle mult and iterative div, data SRAM request; EXE_FWD_EN adds es_fwd_bus.
// Latency: 1 cycle; div/divu hold the stage for DIV_CYCLES+1 cycles before issuing.
// Backpressure: es_allowin drops while a divide runs or ms_allowin is low with a valid result.
module exe_stage
    import exe_stage_pkg::*;
#(
    parameter int DIV_CYCLES = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ms_allowin,
    output logic                       es_allowin,
    input  logic                       ds_to_es_valid,
    input  logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus,
    output logic                       es_to_ms_valid,
    output logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    input  logic                       ws_flush,
    output logic                       data_sram_en,
    output logic [3:0]                 data_sram_wen,
    output logic [31:0]                data_sram_addr,
    output logic [31:0]                data_sram_wdata
`ifdef EXE_FWD_EN
    ,
    output logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus
`endif
);

    logic        es_valid;
    ds_to_es_t   es_bus;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        es_ready_go;
    logic        es_leave;
    logic        is_div;
    logic        hilo_we;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_q;
    logic [31:0] div_r;
    logic [31:0] alu_src1;
    logic [31:0] alu_src2;
    logic [31:0] alu_result;
    logic [31:0] es_result;
    logic [63:0] prod;
    es_to_ms_t   out;

    assign is_div         = es_valid && es_bus.md_op[MD_OP_DIV] && !es_bus.ex;
    assign es_ready_go    = is_div ? div_done : 1'b1;
    assign es_allowin     = !es_valid || (es_ready_go && ms_allowin);
    assign es_to_ms_valid = es_valid && es_ready_go;
    assign es_leave       = es_to_ms_valid && ms_allowin;
    assign hilo_we        = es_leave && !es_bus.ex && !ws_flush;

    always_ff @(posedge clk) begin
        if (reset)           es_valid <= 1'b0;
        else if (ws_flush)   es_valid <= 1'b0;
        else if (es_allowin) es_valid <= ds_to_es_valid;
    end

    always_ff @(posedge clk) begin
        if (reset)                             es_bus <= '0;
        else if (ds_to_es_valid && es_allowin) es_bus <= ds_to_es_bus;
    end

    // Retiring a finished divide reuses abort to send the divider back to IDLE.
    div_iter #(.DIV_CYCLES(DIV_CYCLES)) u_div (
        .clk       (clk),
        .reset     (reset),
        .start     (is_div && !div_busy && !div_done),
        .abort     (ws_flush || (es_leave && is_div)),
        .signed_op (es_bus.signed_op),
        .x         (es_bus.rs_value),
        .y         (es_bus.rt_value),
        .busy      (div_busy),
        .done      (div_done),
        .q         (div_q),
        .r         (div_r)
    );

    assign prod = es_bus.signed_op
                ? ({{32{es_bus.rs_value[31]}}, es_bus.rs_value} * {{32{es_bus.rt_value[31]}}, es_bus.rt_value})
                : ({32'b0, es_bus.rs_value} * {32'b0, es_bus.rt_value});

    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
            lo <= '0;
        end else if (hilo_we) begin
            if (es_bus.md_op[MD_OP_MULT]) {hi, lo} <= prod;
            if (es_bus.md_op[MD_OP_DIV]) begin
                lo <= div_q;
                hi <= div_r;
            end
            if (es_bus.md_op[MD_OP_MTHI]) hi <= es_bus.rs_value;
            if (es_bus.md_op[MD_OP_MTLO]) lo <= es_bus.rs_value;
        end
    end

    assign alu_src1 = es_bus.src1_is_sa  ? {27'b0, es_bus.imm[10:6]} :
                      es_bus.src1_is_pc  ? es_bus.pc : es_bus.rs_value;
    assign alu_src2 = es_bus.src2_is_imm ? {{16{es_bus.imm[15]}}, es_bus.imm} :
                      es_bus.src2_is_8   ? 32'd8 : es_bus.rt_value;

    alu u_alu (
        .alu_op     (es_bus.alu_op),
        .alu_src1   (alu_src1),
        .alu_src2   (alu_src2),
        .alu_result (alu_result)
    );

    always_comb begin
        es_result = alu_result;
        if (es_bus.md_op[MD_OP_MFHI])      es_result = hi;
        else if (es_bus.md_op[MD_OP_MFLO]) es_result = lo;
    end

    always_comb begin
        out              = '0;
        out.ex           = es_bus.ex;
        out.excode       = es_bus.excode;
        out.res_from_mem = es_bus.res_from_mem;
        out.gr_we        = es_bus.gr_we && !es_bus.ex;
        out.dest         = es_bus.dest;
        out.result       = es_result;
        out.pc           = es_bus.pc;
    end
    assign es_to_ms_bus = out;

    assign data_sram_en    = es_valid && (es_bus.res_from_mem || es_bus.mem_we) && !es_bus.ex && !ws_flush;
    assign data_sram_wen   = {4{es_bus.mem_we && data_sram_en}};
    assign data_sram_addr  = alu_result;
    assign data_sram_wdata = es_bus.rt_value;

`ifdef EXE_FWD_EN
    assign es_fwd_bus = {es_valid && out.gr_we && !es_bus.res_from_mem, es_bus.dest, es_result};
`endif

endmodule

// File: tb/tb_exe_stage.sv
// Directed bench for exe_stage: ALU, mult/div with HI/LO, SRAM request, exceptions, flush, stalls.
module tb_exe_stage;
    import exe_stage_pkg::*;

    logic                       clk = 1'b0;
    logic                       reset;
    logic                       ms_allowin;
    logic                       es_allowin;
    logic                       ds_to_es_valid;
    logic [DS_TO_ES_BUS_WD-1:0] ds_to_es_bus;
    logic                       es_to_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus;
    logic                       ws_flush;
    logic                       data_sram_en;
    logic [3:0]                 data_sram_wen;
    logic [31:0]                data_sram_addr;
    logic [31:0]                data_sram_wdata;
`ifdef EXE_FWD_EN
    logic [ES_FWD_BUS_WD-1:0]   es_fwd_bus;
`endif
    es_to_ms_t                  o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;
    assign o = es_to_ms_bus;

    exe_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ms_allowin      (ms_allowin),
        .es_allowin      (es_allowin),
        .ds_to_es_valid  (ds_to_es_valid),
        .ds_to_es_bus    (ds_to_es_bus),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ws_flush        (ws_flush),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata)
`ifdef EXE_FWD_EN
        ,
        .es_fwd_bus      (es_fwd_bus)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input ds_to_es_t b);
        ds_to_es_bus   = b;
        ds_to_es_valid = 1'b1;
        tick();
        ds_to_es_valid = 1'b0;
    endtask

    task automatic wait_allowin(output int n);
        n = 0;
        while (!es_allowin && n < 200) begin
            n++;
            tick();
        end
    endtask

    function automatic ds_to_es_t op_alu(input int op, input logic [4:0] dest,
                                         input logic [31:0] rs, input logic [31:0] rt);
        ds_to_es_t b;
        b            = '0;
        b.alu_op[op] = 1'b1;
        b.gr_we      = 1'b1;
        b.dest       = dest;
        b.rs_value   = rs;
        b.rt_value   = rt;
        b.pc         = 32'hBFC0_0100;
        return b;
    endfunction

    function automatic ds_to_es_t op_md(input int md, input logic sgn,
                                        input logic [31:0] rs, input logic [31:0] rt);
        ds_to_es_t b;
        b           = '0;
        b.md_op[md] = 1'b1;
        b.signed_op = sgn;
        b.gr_we     = (md == MD_OP_MFHI) || (md == MD_OP_MFLO);
        b.dest      = 5'd8;
        b.rs_value  = rs;
        b.rt_value  = rt;
        b.pc        = 32'hBFC0_0200;
        return b;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        ds_to_es_t b;
        int        n;

        reset          = 1'b1;
        ms_allowin     = 1'b1;
        ds_to_es_valid = 1'b0;
        ds_to_es_bus   = '0;
        ws_flush       = 1'b0;
        repeat (3) tick();
        check("rst_es_to_ms_valid", 32'(es_to_ms_valid), 32'd0);
        check("rst_es_allowin",     32'(es_allowin),     32'd1);
        check("rst_sram_en",        32'(data_sram_en),   32'd0);
        check("rst_sram_wen",       32'(data_sram_wen),  32'd0);
        check("rst_hi",             dut.hi,              32'd0);
        check("rst_lo",             dut.lo,              32'd0);
        reset = 1'b0;
        tick();

        // addu 5 + 7
        send(op_alu(ALU_ADD, 5'd3, 32'd5, 32'd7));
        check("addu_valid",  32'(es_to_ms_valid), 32'd1);
        check("addu_result", o.result,            32'd12);
        check("addu_gr_we",  32'(o.gr_we),        32'd1);
        check("addu_dest",   32'(o.dest),         32'd3);
        check("addu_sram",   32'(data_sram_en),   32'd0);
`ifdef EXE_FWD_EN
        check("addu_fwd", 32'(es_fwd_bus), {1'b1, 5'd3, 26'd0} | 32'd12);
`endif
        tick();
        check("bubble_valid", 32'(es_to_ms_valid), 32'd0);

        // signed div -7 / 2 -> q=-3, r=-1
        send(op_md(MD_OP_DIV, 1'b1, 32'hFFFF_FFF9, 32'd2));
        wait_allowin(n);
        check("div_stall_cycles", 32'(n), 32'd33);
        check("div_done_valid", 32'(es_to_ms_valid), 32'd1);
        send(op_md(MD_OP_MFLO, 1'b0, 32'd0, 32'd0));
        check("div_mflo", o.result, 32'hFFFF_FFFD);
        check("div_mflo_valid", 32'(es_to_ms_valid), 32'd1);
        send(op_md(MD_OP_MFHI, 1'b0, 32'd0, 32'd0));
        check("div_mfhi", o.result, 32'hFFFF_FFFF);

        // multu 0xFFFFFFFF * 2 -> HI=1, LO=0xFFFFFFFE
        send(op_md(MD_OP_MULT, 1'b0, 32'hFFFF_FFFF, 32'd2));
        check("multu_no_stall", 32'(es_to_ms_valid), 32'd1);
        send(op_md(MD_OP_MFHI, 1'b0, 32'd0, 32'd0));
        check("multu_mfhi", o.result, 32'd1);
        check("multu_mfhi_valid", 32'(es_to_ms_valid), 32'd1);
        send(op_md(MD_OP_MFLO, 1'b0, 32'd0, 32'd0));
        check("multu_mflo", o.result, 32'hFFFF_FFFE);

        // sw, lw, then sw carrying an exception
        b = op_alu(ALU_ADD, 5'd0, 32'h0000_1000, 32'hCAFE_BABE);
        b.src2_is_imm = 1'b1; b.imm = 16'h0010; b.mem_we = 1'b1; b.gr_we = 1'b0;
        send(b);
        check("sw_en",    32'(data_sram_en),  32'd1);
        check("sw_wen",   32'(data_sram_wen), 32'hF);
        check("sw_addr",  data_sram_addr,     32'h0000_1010);
        check("sw_wdata", data_sram_wdata,    32'hCAFE_BABE);
        b = op_alu(ALU_ADD, 5'd9, 32'h0000_2000, 32'd0);
        b.src2_is_imm = 1'b1; b.imm = 16'hFFFC; b.res_from_mem = 1'b1;
        send(b);
        check("lw_en",   32'(data_sram_en),  32'd1);
        check("lw_wen",  32'(data_sram_wen), 32'd0);
        check("lw_addr", data_sram_addr,     32'h0000_1FFC);
        b = op_alu(ALU_ADD, 5'd4, 32'h0000_1001, 32'd1);
        b.src2_is_imm = 1'b1; b.mem_we = 1'b1; b.ex = 1'b1; b.excode = EXC_ADES - 5'd1;
        send(b);
        check("exc_sw_wen",    32'(data_sram_wen), 32'd0);
        check("exc_sw_en",     32'(data_sram_en),  32'd0);
        check("exc_sw_ex",     32'(o.ex),          32'd1);
        check("exc_sw_excode", 32'(o.excode),      32'h04);
        check("exc_sw_gr_we",  32'(o.gr_we),       32'd0);
        b = op_md(MD_OP_DIV, 1'b1, 32'd9, 32'd3);
        b.ex = 1'b1; b.excode = EXC_RI;
        send(b);
        check("exc_div_no_stall", 32'(es_to_ms_valid), 32'd1);
        send(op_md(MD_OP_MFLO, 1'b0, 32'd0, 32'd0));
        check("exc_div_lo_kept", o.result, 32'hFFFF_FFFE);

        // flush at cycle 10 of a divide
        send(op_md(MD_OP_DIV, 1'b1, 32'd100, 32'd7));
        repeat (10) tick();
        ws_flush = 1'b1;
        tick();
        ws_flush = 1'b0;
        check("flush_valid",   32'(es_to_ms_valid),    32'd0);
        check("flush_allowin", 32'(es_allowin),        32'd1);
        check("flush_fsm",     32'(dut.u_div.state),   32'(DIV_IDLE));
        send(op_alu(ALU_ADD, 5'd5, 32'd1, 32'd2));
        check("flush_addu", o.result, 32'd3);
        check("flush_addu_valid", 32'(es_to_ms_valid), 32'd1);
        send(op_md(MD_OP_MFHI, 1'b0, 32'd0, 32'd0));
        check("flush_hi_kept", o.result, 32'd1);
        send(op_md(MD_OP_MFLO, 1'b0, 32'd0, 32'd0));
        check("flush_lo_kept", o.result, 32'hFFFF_FFFE);
        ds_to_es_bus   = op_alu(ALU_ADD, 5'd6, 32'd4, 32'd4);
        ds_to_es_valid = 1'b1;
        ws_flush       = 1'b1;
        tick();
        ds_to_es_valid = 1'b0;
        ws_flush       = 1'b0;
        check("flush_beats_load", 32'(es_to_ms_valid), 32'd0);

        // divu by zero
        send(op_md(MD_OP_DIV, 1'b0, 32'd100, 32'd0));
        wait_allowin(n);
        check("divz_stall_cycles", 32'(n), 32'd33);
        send(op_md(MD_OP_MFLO, 1'b0, 32'd0, 32'd0));
        check("divz_lo", o.result, 32'hFFFF_FFFF);
        send(op_md(MD_OP_MFHI, 1'b0, 32'd0, 32'd0));
        check("divz_hi", o.result, 32'd100);
        tick();

        // done divide held by ms_allowin=0, then back-to-back divu
        ms_allowin = 1'b0;
        send(op_md(MD_OP_DIV, 1'b1, 32'd100, 32'd7));
        n = 0;
        while (!es_to_ms_valid && n < 200) begin
            n++;
            tick();
        end
        check("hold_div_cycles", 32'(n), 32'd33);
        for (int i = 0; i < 5; i++) begin
            check("hold_allowin", 32'(es_allowin),     32'd0);
            check("hold_valid",   32'(es_to_ms_valid), 32'd1);
            check("hold_lo",      dut.lo,              32'hFFFF_FFFF);
            check("hold_hi",      dut.hi,              32'd100);
            tick();
        end
        ms_allowin = 1'b1;
        send(op_md(MD_OP_DIV, 1'b0, 32'd7, 32'd2));
        check("release_lo", dut.lo, 32'd14);
        check("release_hi", dut.hi, 32'd2);
        wait_allowin(n);
        check("b2b_stall_cycles", 32'(n), 32'd33);
        send(op_md(MD_OP_MFLO, 1'b0, 32'd0, 32'd0));
        check("b2b_lo", o.result, 32'd3);
        send(op_md(MD_OP_MFHI, 1'b0, 32'd0, 32'd0));
        check("b2b_hi", o.result, 32'd1);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
